// File: rtl/vdg_fetch_responder.sv
// Memory-side responder for VDG display fetches. Shares one video SRAM port between
// display reads (always first) and CPU reads/writes in the slots the display leaves free.
module vdg_fetch_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned BASE_W  = 7,
  parameter int unsigned RAM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [12:0]       da_i,
  input  logic              load_i,
  input  logic              fsn_i,
  input  logic [BASE_W-1:0] base_i,
  output logic [7:0]        q_o,
  output logic              q_valid_o,
  output logic              overrun_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rd_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_wdata_i,
  output logic [7:0]        cpu_rdata_o,
  output logic              cpu_ack_o
);

  localparam int unsigned CntW = $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StVrd, StCrd, StCwr} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              load_q;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_rd_q, ram_rd_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;

  logic              fetch_ev;
  logic              done;
  logic [ADDR_W-1:0] vaddr;

  assign fetch_ev = load_i & ~load_q;
  // Base is in 512-byte units; the sum wraps modulo 2^ADDR_W.
  assign vaddr    = ADDR_W'({base_i, 9'b0}) + ADDR_W'(da_i);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    overrun_d   = fsn_i ? overrun_q : 1'b0;
    q_d         = q_q;
    q_valid_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: done = 1'b1;
      StVrd: begin
        if (cnt_q == CntW'(RAM_LAT)) begin
          q_d       = ram_rdata_i;
          q_valid_d = 1'b1;
          done      = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCrd: begin
        if (cnt_q == CntW'(RAM_LAT)) begin
          cpu_rdata_d = ram_rdata_i;
          cpu_ack_d   = 1'b1;
          done        = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCwr: begin
        cpu_ack_d = 1'b1;
        done      = 1'b1;
      end
    endcase

    if (done) begin
      if (fetch_ev || pend_q) begin
        state_d    = StVrd;
        cnt_d      = '0;
        ram_rd_d   = 1'b1;
        ram_addr_d = fetch_ev ? vaddr : pend_addr_q;
        pend_d     = 1'b0;
        if (fetch_ev && pend_q) overrun_d = 1'b1;
      // The CPU still holds req while its ack is being issued; do not regrant it then.
      end else if (cpu_req_i && !cpu_ack_q && !cpu_ack_d) begin
        cnt_d      = '0;
        ram_addr_d = cpu_addr_i;
        if (cpu_we_i) begin
          state_d     = StCwr;
          ram_wr_d    = 1'b1;
          ram_wdata_d = cpu_wdata_i;
        end else begin
          state_d  = StCrd;
          ram_rd_d = 1'b1;
        end
      end else begin
        state_d = StIdle;
      end
    end else if (fetch_ev) begin
      pend_d      = 1'b1;
      pend_addr_d = vaddr;
      if (pend_q) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      overrun_q   <= 1'b0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_i;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      overrun_q   <= overrun_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      ram_addr_q  <= ram_addr_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign q_o         = q_q;
  assign q_valid_o   = q_valid_q;
  assign overrun_o   = overrun_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_rd_o    = ram_rd_q;
  assign ram_wr_o    = ram_wr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_ack_o   = cpu_ack_q;

  // A CPU request, once raised, must be held until the ack has been seen.
  cpu_req_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cpu_req_i && !cpu_ack_q) |=> cpu_req_i);

endmodule

// File: tb/tb_vdg_fetch_responder.sv
// Directed bench for vdg_fetch_responder: SRAM model, transaction-level checker, literal pins.
module tb_vdg_fetch_responder;

  localparam int L = 2;

  logic        clk, rst_n;
  logic [12:0] da;
  logic        load, fsn;
  logic [6:0]  base;
  logic [7:0]  q;
  logic        q_valid, overrun;
  logic [15:0] ram_addr;
  logic        ram_rd, ram_wr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;

  int checks = 0;
  int errors = 0;

  vdg_fetch_responder #(.ADDR_W(16), .BASE_W(7), .RAM_LAT(L)) dut (
    .clk_i(clk), .rst_ni(rst_n), .da_i(da), .load_i(load), .fsn_i(fsn), .base_i(base),
    .q_o(q), .q_valid_o(q_valid), .overrun_o(overrun), .ram_addr_o(ram_addr),
    .ram_rd_o(ram_rd), .ram_wr_o(ram_wr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SRAM contents: a fixed pattern, one pinned byte, plus whatever the DUT writes.
  logic [7:0] wmem [int];
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    if (a == 16'h0415) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic       pv [0:3];
  logic [7:0] pd [0:3];
  always @(posedge clk) begin
    if (ram_wr) wmem[int'(ram_addr)] = ram_wdata;
    pv[0] <= ram_rd;
    pd[0] <= mem_rd(ram_addr);
    for (int i = 1; i < 4; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  // Junk outside the valid slot so a mistimed sample is visible.
  assign ram_rdata = pv[L-1] ? pd[L-1] : 8'hEE;

  // Expected display fetch addresses, in order, as pushed by the stimulus.
  logic [15:0] exp_vq [$];

  int          cyc = 16;
  logic        h_rd [0:15];
  logic        h_wr [0:15];
  logic [15:0] h_addr [0:15];
  logic [7:0]  h_wdata [0:15];
  logic [7:0]  last_q = 8'h00;

  always @(negedge clk) begin
    int ir, iw;
    logic [15:0] ev;
    cyc++;
    ir = (cyc - L - 1) % 16;
    iw = (cyc - 1) % 16;
    if (!rst_n) begin
      chk("reset_outputs", {q, q_valid, overrun, ram_addr, ram_rd, ram_wr, ram_wdata,
                            cpu_rdata, cpu_ack}, 64'h0);
      last_q = 8'h00;
    end else begin
      chk("rd_wr_exclusive", {63'h0, ram_rd & ram_wr}, 64'h0);
      if (q_valid) begin
        if (exp_vq.size() == 0) begin
          chk("unexpected_q_valid", 64'h1, 64'h0);
        end else begin
          ev = exp_vq.pop_front();
          chk("vfetch_issue", {h_rd[ir], h_addr[ir]}, {1'b1, ev});
          chk("q_data", q, mem_rd(ev));
        end
      end else begin
        chk("q_hold", q, last_q);
      end
      if (cpu_ack) begin
        if (cpu_we) begin
          chk("cwr_issue", {h_wr[iw], h_addr[iw], h_wdata[iw]}, {1'b1, cpu_addr, cpu_wdata});
        end else begin
          chk("crd_issue", {h_rd[ir], h_addr[ir]}, {1'b1, cpu_addr});
          chk("cpu_rdata", cpu_rdata, mem_rd(cpu_addr));
        end
      end
      last_q = q;
    end
    h_rd[cyc % 16]    = ram_rd;
    h_wr[cyc % 16]    = ram_wr;
    h_addr[cyc % 16]  = ram_addr;
    h_wdata[cyc % 16] = ram_wdata;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ticks until q_valid (which=0) or cpu_ack (which=1); n hits 20 on timeout.
  task automatic wait_for(input int which, output int n);
    n = 0;
    while (n < 20) begin
      tick(1);
      n++;
      if ((which == 0) ? q_valid : cpu_ack) break;
    end
  endtask

  initial begin
    int n, cnt;
    rst_n = 1'b0; load = 1'b0; fsn = 1'b1; base = '0; da = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(3);
    chk("reset_state", {q, q_valid, overrun, ram_rd, ram_wr, cpu_ack, ram_addr}, 64'h0);
    rst_n = 1'b1;
    tick(2);

    // Basic fetch and held-load single event
    base = 7'h02; da = 13'h0015; load = 1'b1; exp_vq.push_back(16'h0415);
    tick(1);
    chk("basic_rd", {ram_rd, ram_addr}, {1'b1, 16'h0415});
    wait_for(0, n);
    chk("basic_latency", n, L + 1);
    chk("basic_q", q, 8'hA5);
    cnt = 0;
    repeat (10) begin
      tick(1);
      cnt += int'(ram_rd);
    end
    chk("held_load_no_refetch", cnt, 0);
    load = 1'b0;
    tick(2);

    // Reset in the middle of a display read
    base = 7'h00; da = 13'h0010; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {q, ram_rd, ram_addr, q_valid}, 64'h0);
    tick(2);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick(1);
      cnt += int'(q_valid);
    end
    chk("no_qvalid_after_reset", cnt, 0);

    // Address wrap: {7F,9'b0} + 0x300 wraps to 0x0100
    base = 7'h7F; da = 13'h0300; load = 1'b1; exp_vq.push_back(16'h0100);
    tick(1);
    chk("wrap_rd", {ram_rd, ram_addr}, {1'b1, 16'h0100});
    wait_for(0, n);
    chk("wrap_latency", n, L + 1);
    chk("wrap_q", q, 8'h5B);
    load = 1'b0;
    tick(2);

    // Display and CPU read on the same edge: display first
    base = 7'h00; da = 13'h0020; load = 1'b1; exp_vq.push_back(16'h0020);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    tick(1);
    chk("prio_video_first", {ram_rd, ram_addr}, {1'b1, 16'h0020});
    load = 1'b0;
    wait_for(0, n);
    chk("prio_video_latency", n, L + 1);
    chk("prio_cpu_issue", {ram_rd, ram_addr, cpu_ack}, {1'b1, 16'h1234, 1'b0});
    wait_for(1, n);
    chk("prio_cpu_latency", n, L + 1);
    chk("prio_cpu_rdata", cpu_rdata, 8'h7C);
    tick(1);
    chk("prio_ack_pulse", cpu_ack, 1'b0);
    cpu_req = 1'b0;
    tick(2);

    // Load event during a CPU write: video read follows back-to-back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h3C;
    tick(1);
    chk("pend_wr", {ram_wr, ram_rd, ram_addr}, {1'b1, 1'b0, 16'h2000});
    base = 7'h00; da = 13'h0040; load = 1'b1; exp_vq.push_back(16'h0040);
    tick(1);
    chk("pend_ack_and_rd", {cpu_ack, ram_rd, ram_wr, ram_addr}, {1'b1, 1'b1, 1'b0, 16'h0040});
    tick(1);
    cpu_req = 1'b0; load = 1'b0;
    wait_for(0, n);
    // One cycle of the fetch latency was already spent above.
    chk("pend_latency", n, L);
    chk("pend_q", q, 8'h1A);
    chk("pend_no_overrun", overrun, 1'b0);
    tick(2);

    // Two load events during one CPU read: only the newest is fetched
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    tick(1);
    chk("ovr_cpu_rd", {ram_rd, ram_addr}, {1'b1, 16'h3000});
    da = 13'h0001; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    da = 13'h0002; load = 1'b1; exp_vq.push_back(16'h0002);
    tick(1);
    chk("ovr_switch", {cpu_ack, ram_rd, ram_addr, overrun}, {1'b1, 1'b1, 16'h0002, 1'b1});
    tick(1);
    cpu_req = 1'b0; load = 1'b0;
    wait_for(0, n);
    chk("ovr_latency", n, L);
    chk("ovr_q", q, 8'h58);
    chk("ovr_sticky", overrun, 1'b1);
    fsn = 1'b0;
    tick(1);
    chk("ovr_cleared_by_fsn", overrun, 1'b0);
    fsn = 1'b1;
    tick(3);

    chk("all_fetches_seen", exp_vq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vdg_fetch_responder.md
Name: vdg_fetch_responder

Overview:
- Memory-side responder to the VDG display fetch interface. Takes the VDG's display address (DA) and fetch strobe (DataPreLoad), adds the SAM-style display base offset, reads one byte from shared video SRAM, and returns it on Q.
- Arbitrates CPU access to the same SRAM in slots the display does not need. Display fetches always have priority.
- Sits between the MC6847X top-level and the board SRAM, clocked from the same clock as the VDG frame timing.

Parameters:
- ADDR_W, 16: SRAM/CPU address width.
- BASE_W, 7: display base register width. The base is in 512-byte units.
- RAM_LAT, 2: SRAM read latency in clocks, from the ram_rd cycle to rdata being sampled. Legal range is 1..4.

Ports:
- clk  in  1  system clock (NTSCClk domain).
- resetn  in  1  asynchronous active-low reset.
- da  in  13  display address from the VDG.
- load  in  1  fetch strobe (DataPreLoad). Only a rising edge is acted on.
- fsn  in  1  frame sync, active low. Clears the overrun flag.
- base  in  BASE_W  display base. Effective address = {base, 9'b0} + da.
- q  out  8  display data to the VDG.
- q_valid  out  1  one-clock pulse when q is updated.
- overrun  out  1  sticky flag: a display fetch was dropped or replaced.
- ram_addr  out  ADDR_W  SRAM address.
- ram_rd  out  1  SRAM read strobe, one clock per access.
- ram_wr  out  1  SRAM write strobe, one clock per access.
- ram_wdata  out  8  SRAM write data.
- ram_rdata  in  8  SRAM read data, valid RAM_LAT clocks after ram_rd.
- cpu_req  in  1  CPU access request (level). Held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read. Stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data, valid when cpu_ack is high.
- cpu_ack  out  1  one-clock completion pulse.

Behaviour:

Reset:
- resetn low forces all outputs to 0 and the FSM to IDLE. It also clears the pending flag, the pending address, load_d and the latency counter.
- This takes effect immediately and mid-operation. An in-flight read is abandoned; no q_valid or cpu_ack follows.

Edge detect:
- load_d is registered every clock.
- A fetch event is load==1 && load_d==0. A held-high load produces exactly one event.

Address:
- vaddr = ({base, 9'b0} + zero-extended da), truncated to ADDR_W, so it wraps modulo 2^ADDR_W.
- base and da are sampled at the edge where the event is detected.

FSM states: IDLE, VRD, CRD, CWR. All outputs are registered.
- IDLE: on an event (or pending set) go to VRD. Otherwise, if cpu_req is high, go to CRD (cpu_we=0) or CWR (cpu_we=1). Otherwise stay in IDLE.
- If an event and cpu_req arrive on the same edge, the display wins and the CPU waits.
- VRD:
  - ram_rd=1 and ram_addr=vaddr for exactly the first cycle; the latency counter then counts.
  - At the edge RAM_LAT clocks after ram_rd was asserted: q<=ram_rdata and q_valid=1 for one cycle.
  - Load-event edge to q_valid high is RAM_LAT+1 clocks when starting from IDLE.
- CRD:
  - ram_rd=1 with ram_addr=cpu_addr for one cycle.
  - RAM_LAT clocks later, cpu_rdata<=ram_rdata and cpu_ack=1 for one cycle.
- CWR:
  - ram_wr=1 with ram_addr=cpu_addr and ram_wdata=cpu_wdata for one cycle.
  - cpu_ack=1 in the following cycle.
- Completion edge (any state): if pending is set, go straight to VRD (back-to-back, no idle cycle). Otherwise follow the IDLE rules. ram_rd and ram_wr are never high together.

Pending and overrun:
- An event while not in IDLE sets pending and latches vaddr.
- An event while pending is already set replaces the latched address with the newest vaddr and sets overrun.
- overrun clears on any clock where fsn==0. If fsn==0 and a new overrun occur on the same edge, set wins.
- q holds its value between updates.

CPU rules:
- cpu_ack is never issued without a prior grant.
- Dropping cpu_req before ack is illegal. Checked by assertion only.

Test Plan:
- Reset/idle: resetn low mid-VRD, then high -> all outputs 0, no q_valid. The next load edge produces a normal fetch.
- Basic fetch: base=7'h02, da=13'h0015, load rising, RAM model returns 8'hA5 -> ram_rd once with ram_addr=16'h0415; q=8'hA5 with q_valid high RAM_LAT+1 clocks after the event. Holding load high for 10 clocks gives no second fetch.
- Wrap: base=7'h7F, da=13'h0300 -> ram_addr=16'h0100.
- Priority: load rising and cpu_req (read, addr 16'h1234) on the same edge -> the video read issues first. The CPU read issues after q_valid; cpu_rdata is correct and cpu_ack is one pulse.
- Pending: a CPU write is in progress when the load event arrives (da=13'h0040, base=0) -> ram_wr, cpu_ack, then ram_rd addr 16'h0040 with no gap. overrun stays 0.
- Overrun: two load events during one CPU read, da=13'h0001 then 13'h0002 -> only 16'h0002 is fetched and overrun=1. fsn pulsed low -> overrun=0.
